// File: rtl/ram_write_scheduler.sv
// Write-port scheduler in front of the multi-port RAM: one batch of requests is
// spread over the RAM write ports without two ports ever carrying the same
// address. Optional macro RAM_WAW_MERGE_EN merges same-address entries byte-wise.
module ram_write_scheduler #(
  parameter int REQ_NUM          = 8,
  parameter int WPORTS_NUM       = 6,
  parameter int DATA_DEPTH       = 128,
  parameter int DATA_WIDTH       = 64,
  parameter int BYTE_WRITE_WIDTH = 8,
  localparam int ADDR_WIDTH      = $clog2(DATA_DEPTH),
  localparam int BYTES_NUM       = DATA_WIDTH / BYTE_WRITE_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [REQ_NUM-1:0]                    req_valid_i,
  output logic                                  req_ready_o,
  input  logic [REQ_NUM-1:0][ADDR_WIDTH-1:0]    req_addr_i,
  input  logic [REQ_NUM-1:0][BYTES_NUM-1:0]     req_we_i,
  input  logic [REQ_NUM-1:0][DATA_WIDTH-1:0]    req_data_i,
  output logic [WPORTS_NUM-1:0]                 en_w_o,
  output logic [WPORTS_NUM-1:0][BYTES_NUM-1:0]  we_o,
  output logic [WPORTS_NUM-1:0][ADDR_WIDTH-1:0] waddr_o,
  output logic [WPORTS_NUM-1:0][DATA_WIDTH-1:0] data_o,
  output logic                                  busy_o
);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t                                state;
  logic [REQ_NUM-1:0]                    pend_p0;
  logic [REQ_NUM-1:0][ADDR_WIDTH-1:0]    addr_p0;
  logic [REQ_NUM-1:0][BYTES_NUM-1:0]     we_p0;
  logic [REQ_NUM-1:0][DATA_WIDTH-1:0]    data_p0;

  logic [WPORTS_NUM-1:0]                 sel_en;
  logic [WPORTS_NUM-1:0][ADDR_WIDTH-1:0] sel_addr;
  logic [WPORTS_NUM-1:0][BYTES_NUM-1:0]  sel_we;
  logic [WPORTS_NUM-1:0][DATA_WIDTH-1:0] sel_data;
  logic [REQ_NUM-1:0]                    take;
  logic [REQ_NUM-1:0]                    rem_pend;
  logic [REQ_NUM-1:0]                    load_pend;
  logic                                  drained;

  // Stage p0 -> group selection: first WPORTS_NUM distinct pending addresses
  always_comb begin
    int   cnt;
    logic dup;
    cnt      = 0;
    dup      = 1'b0;
    sel_en   = '0;
    sel_addr = '0;
    sel_we   = '0;
    sel_data = '0;
    take     = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      dup = 1'b0;
      for (int k = 0; k < i; k++)
        if (pend_p0[k] && (addr_p0[k] == addr_p0[i])) dup = 1'b1;
      if (pend_p0[i] && !dup) begin
        for (int j = 0; j < WPORTS_NUM; j++) begin
          if (j == cnt) begin
            sel_en[j]   = 1'b1;
            sel_addr[j] = addr_p0[i];
`ifndef RAM_WAW_MERGE_EN
            take[i]     = 1'b1;
            sel_we[j]   = we_p0[i];
            sel_data[j] = data_p0[i];
`endif
          end
        end
        cnt = cnt + 1;
      end
    end
`ifdef RAM_WAW_MERGE_EN
    // Ascending scan so the highest-index entry owns each enabled byte
    for (int j = 0; j < WPORTS_NUM; j++) begin
      for (int i = 0; i < REQ_NUM; i++) begin
        if (sel_en[j] && pend_p0[i] && (addr_p0[i] == sel_addr[j])) begin
          take[i]   = 1'b1;
          sel_we[j] = sel_we[j] | we_p0[i];
          for (int b = 0; b < BYTES_NUM; b++)
            if (we_p0[i][b])
              sel_data[j][b*BYTE_WRITE_WIDTH +: BYTE_WRITE_WIDTH] =
                data_p0[i][b*BYTE_WRITE_WIDTH +: BYTE_WRITE_WIDTH];
        end
      end
    end
`endif
  end

  always_comb begin
    load_pend = '0;
    for (int i = 0; i < REQ_NUM; i++)
      load_pend[i] = req_valid_i[i] && (req_we_i[i] != '0);
  end

  assign rem_pend    = pend_p0 & ~take;
  assign drained     = (rem_pend == '0);
  assign req_ready_o = !rst && drained;
  assign busy_o      = (state == DRAIN);

  // Stage p0 -> p1: batch control and registered RAM port outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pend_p0 <= '0;
      en_w_o  <= '0;
      we_o    <= '0;
      waddr_o <= '0;
      data_o  <= '0;
    end else begin
      en_w_o  <= sel_en;
      we_o    <= sel_we;
      waddr_o <= sel_addr;
      data_o  <= sel_data;
      if (drained) begin
        pend_p0 <= load_pend;
        state   <= (load_pend != '0) ? DRAIN : IDLE;
      end else begin
        pend_p0 <= rem_pend;
        state   <= DRAIN;
      end
    end
  end

  // Batch payload only matters where pend_p0 is set, so it carries no reset
  always_ff @(posedge clk) begin
    if (req_ready_o) begin
      addr_p0 <= req_addr_i;
      we_p0   <= req_we_i;
      data_p0 <= req_data_i;
    end
  end

endmodule

// File: tb/tb_ram_write_scheduler.sv
// Scoreboard bench for ram_write_scheduler: directed scenarios plus random batches
// compared against a queue-based reference of the grouping and merge rules.
module tb_ram_write_scheduler;

  localparam int RN = 8;
  localparam int WP = 6;
  localparam int AW = 7;
  localparam int DW = 64;
  localparam int BN = 8;

  typedef logic [RN-1:0][AW-1:0] addr_vec_t;
  typedef logic [RN-1:0][BN-1:0] we_vec_t;
  typedef logic [RN-1:0][DW-1:0] data_vec_t;

  typedef struct {
    logic [WP-1:0]         en;
    logic [WP-1:0][AW-1:0] addr;
    logic [WP-1:0][BN-1:0] we;
    logic [WP-1:0][DW-1:0] data;
  } grp_t;

  logic                  clk;
  logic                  rst;
  logic [RN-1:0]         req_valid_i;
  logic                  req_ready_o;
  addr_vec_t             req_addr_i;
  we_vec_t               req_we_i;
  data_vec_t             req_data_i;
  logic [WP-1:0]         en_w_o;
  logic [WP-1:0][BN-1:0] we_o;
  logic [WP-1:0][AW-1:0] waddr_o;
  logic [WP-1:0][DW-1:0] data_o;
  logic                  busy_o;

  int   tests = 0;
  int   fails = 0;
  grp_t exp_q[$];

  ram_write_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .req_we_i    (req_we_i),
    .req_data_i  (req_data_i),
    .en_w_o      (en_w_o),
    .we_o        (we_o),
    .waddr_o     (waddr_o),
    .data_o      (data_o),
    .busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: repeatedly peel off groups of up to WP distinct addresses
  task automatic model_batch(input logic [RN-1:0] v, input addr_vec_t a, input we_vec_t w,
                             input data_vec_t d, output int ng);
    int   idx[$];
    int   rest[$];
    int   sel[$];
    grp_t g;
    bit   seen;
    int   e;
    int   p;
    ng = 0;
    for (int i = 0; i < RN; i++)
      if (v[i] && (w[i] != '0)) idx.push_back(i);
    while (idx.size() > 0) begin
      sel.delete();
      rest.delete();
      g.en = '0; g.addr = '0; g.we = '0; g.data = '0;
      foreach (idx[k]) begin
        seen = 0;
        foreach (sel[s]) if (sel[s] == int'(a[idx[k]])) seen = 1;
        if (!seen && sel.size() < WP) sel.push_back(int'(a[idx[k]]));
      end
      foreach (idx[k]) begin
        e = idx[k];
        p = -1;
        foreach (sel[s]) if (sel[s] == int'(a[e])) p = s;
        if (p < 0) rest.push_back(e);
`ifdef RAM_WAW_MERGE_EN
        else begin
          g.en[p]   = 1'b1;
          g.addr[p] = a[e];
          g.we[p]   = g.we[p] | w[e];
          for (int b = 0; b < BN; b++)
            if (w[e][b]) g.data[p][b*8 +: 8] = d[e][b*8 +: 8];
        end
`else
        else if (g.en[p]) rest.push_back(e);
        else begin
          g.en[p]   = 1'b1;
          g.addr[p] = a[e];
          g.we[p]   = w[e];
          g.data[p] = d[e];
        end
`endif
      end
      exp_q.push_back(g);
      ng++;
      idx = rest;
    end
  endtask

  // Monitor: every port write on the RAM side is matched against the queue head
  always @(negedge clk) begin
    grp_t g;
    if (en_w_o != '0) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got en_w_o=%b, expected no write", en_w_o);
      end else begin
        g = exp_q.pop_front();
        check("sb_en", 64'(en_w_o), 64'(g.en));
        for (int p = 0; p < WP; p++) begin
          if (g.en[p]) begin
            check("sb_addr", 64'(waddr_o[p]), 64'(g.addr[p]));
            check("sb_we", 64'(we_o[p]), 64'(g.we[p]));
            check("sb_data", data_o[p], g.data[p]);
          end
        end
      end
    end
  end

  task automatic send_batch(input logic [RN-1:0] v, input addr_vec_t a, input we_vec_t w,
                            input data_vec_t d, output int ng);
    int waited;
    waited = 0;
    ng = 0;
    req_valid_i = v;
    req_addr_i  = a;
    req_we_i    = w;
    req_data_i  = d;
    while (!req_ready_o && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready_o) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: ready=%b after %0d cycles, expected 1", req_ready_o, waited);
    end else begin
      model_batch(v, a, w, d, ng);
    end
    @(posedge clk);
    #1;
    req_valid_i = '0;
  endtask

  task automatic expect_drain(input int ng);
    int low;
    low = 0;
    @(negedge clk);
    while (!req_ready_o && low < 20) begin
      low++;
      @(negedge clk);
    end
    check("drain_cycles", 64'(low), 64'((ng > 0) ? ng - 1 : 0));
  endtask

  initial begin : stim
    addr_vec_t a;
    we_vec_t   w;
    data_vec_t d;
    int        ng;

    rst         = 1'b1;
    req_valid_i = '1;
    req_we_i    = '1;
    for (int i = 0; i < RN; i++) begin
      req_addr_i[i] = AW'($urandom);
      req_data_i[i] = {$urandom, $urandom};
    end
    repeat (3) begin
      @(negedge clk);
      check("rst_en", 64'(en_w_o), 64'(0));
      check("rst_we", 64'(we_o == '0), 64'(1));
      check("rst_addr", 64'(waddr_o == '0), 64'(1));
      check("rst_data", 64'(data_o == '0), 64'(1));
      check("rst_ready", 64'(req_ready_o), 64'(0));
      check("rst_busy", 64'(busy_o), 64'(0));
    end
    rst = 1'b0;
    req_valid_i = '0;
    @(negedge clk);
    check("post_rst_ready", 64'(req_ready_o), 64'(1));
    check("post_rst_busy", 64'(busy_o), 64'(0));

    // Four distinct addresses fit in one group
    a = '0; w = '0; d = '0;
    for (int i = 0; i < 4; i++) begin
      a[i] = AW'(i + 1);
      w[i] = 8'hFF;
      d[i] = 64'(8'hA0 + i);
    end
    send_batch(8'h0F, a, w, d, ng);
    @(negedge clk);
    check("four_ready_n1", 64'(req_ready_o), 64'(1));
    check("four_en_n1", 64'(en_w_o), 64'(0));
    @(negedge clk);
    check("four_en_n2", 64'(en_w_o), 64'(6'b001111));
    check("four_data3", data_o[3], 64'hA3);
    check("four_ready_n2", 64'(req_ready_o), 64'(1));
    repeat (2) @(negedge clk);

    // Eight distinct addresses need two groups
    for (int i = 0; i < RN; i++) begin
      a[i] = AW'(10 + i);
      w[i] = 8'hFF;
      d[i] = {$urandom, $urandom};
    end
    send_batch(8'hFF, a, w, d, ng);
    @(negedge clk);
    check("eight_ready_n1", 64'(req_ready_o), 64'(0));
    check("eight_busy_n1", 64'(busy_o), 64'(1));
    @(negedge clk);
    check("eight_en_n2", 64'(en_w_o), 64'(6'h3F));
    check("eight_ready_n2", 64'(req_ready_o), 64'(1));
    check("eight_busy_n2", 64'(busy_o), 64'(1));
    @(negedge clk);
    check("eight_en_n3", 64'(en_w_o), 64'(6'b000011));
    check("eight_busy_n3", 64'(busy_o), 64'(0));
    repeat (2) @(negedge clk);

    // Two writes to the same address in slots 0 and 3
    a = '0; w = '0; d = '0;
    a[0] = AW'(5); w[0] = 8'hFF; d[0] = 64'h1111_1111_1111_1111;
    a[3] = AW'(5); w[3] = 8'h0F; d[3] = 64'h2222_2222_2222_2222;
    send_batch(8'b0000_1001, a, w, d, ng);
`ifdef RAM_WAW_MERGE_EN
    @(negedge clk);
    check("waw_ready_n1", 64'(req_ready_o), 64'(1));
    @(negedge clk);
    check("waw_en_n2", 64'(en_w_o), 64'(6'b000001));
    check("waw_we_n2", 64'(we_o[0]), 64'(8'hFF));
    check("waw_data_n2", data_o[0], 64'h1111_1111_2222_2222);
    @(negedge clk);
    check("waw_en_n3", 64'(en_w_o), 64'(0));
`else
    @(negedge clk);
    check("waw_ready_n1", 64'(req_ready_o), 64'(0));
    @(negedge clk);
    check("waw_en_n2", 64'(en_w_o), 64'(6'b000001));
    check("waw_we_n2", 64'(we_o[0]), 64'(8'hFF));
    check("waw_data_n2", data_o[0], 64'h1111_1111_1111_1111);
    check("waw_ready_n2", 64'(req_ready_o), 64'(1));
    @(negedge clk);
    check("waw_en_n3", 64'(en_w_o), 64'(6'b000001));
    check("waw_we_n3", 64'(we_o[0]), 64'(8'h0F));
    check("waw_data_n3", data_o[0], 64'h2222_2222_2222_2222);
`endif
    repeat (2) @(negedge clk);

    // Reset while group 1 of an eight-address batch is on the ports
    for (int i = 0; i < RN; i++) begin
      a[i] = AW'(20 + i);
      w[i] = 8'hFF;
      d[i] = {$urandom, $urandom};
    end
    send_batch(8'hFF, a, w, d, ng);
    @(negedge clk);
    @(negedge clk);
    check("mid_rst_grp1", 64'(en_w_o), 64'(6'h3F));
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_en", 64'(en_w_o), 64'(0));
    check("mid_rst_busy", 64'(busy_o), 64'(0));
    check("mid_rst_ready", 64'(req_ready_o), 64'(0));
    check("mid_rst_left", 64'(exp_q.size()), 64'(1));
    exp_q.delete();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_en_after", 64'(en_w_o), 64'(0));
    check("mid_rst_ready_after", 64'(req_ready_o), 64'(1));

    // Random batches, narrow or wide address range
    for (int n = 0; n < 80; n++) begin
      for (int i = 0; i < RN; i++) begin
        a[i] = (n % 2 == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 127));
        w[i] = ($urandom_range(0, 5) == 0) ? 8'h00 :
               ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
        d[i] = {$urandom, $urandom};
      end
      send_batch(RN'($urandom), a, w, d, ng);
      expect_drain(ng);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("sb_empty", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ram_write_scheduler.md
# ram_write_scheduler

Write-port scheduler sitting directly upstream of the multi-port RAM. It takes a batch of up to REQ_NUM write requests per cycle and maps them onto the RAM's WPORTS_NUM write ports. It resolves same-address (WAW) conflicts the RAM does not handle, so no two RAM write ports ever carry the same address in one cycle. Batches with more distinct addresses than RAM ports are spread over successive cycles, with backpressure to the sources.

## Interface
- REQ_NUM, 8, number of request slots (must be ≥ WPORTS_NUM)
- WPORTS_NUM, 6, RAM write ports driven
- DATA_DEPTH, 128, RAM depth; ADDR_WIDTH = $clog2(DATA_DEPTH) (localparam)
- DATA_WIDTH, 64, data width
- BYTE_WRITE_WIDTH, 8, byte-enable granularity; BYTES_NUM = DATA_WIDTH / BYTE_WRITE_WIDTH (localparam)

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous reset, active-high
- req_valid_i  in  [REQ_NUM]  per-slot request valid
- req_ready_o  out  1  common ready; slot i is accepted on a rising edge where req_valid_i[i] & req_ready_o
- req_addr_i  in  [REQ_NUM][ADDR_WIDTH]  write address
- req_we_i  in  [REQ_NUM][BYTES_NUM]  byte enables
- req_data_i  in  [REQ_NUM][DATA_WIDTH]  write data
- en_w_o  out  [WPORTS_NUM]  RAM port enable
- we_o  out  [WPORTS_NUM][BYTES_NUM]  RAM byte enables
- waddr_o  out  [WPORTS_NUM][ADDR_WIDTH]  RAM address
- data_o  out  [WPORTS_NUM][DATA_WIDTH]  RAM data
- busy_o  out  1  batch register holds pending entries

## Operation
- Batch register: REQ_NUM entries {pending, addr, we, data}. On an accepting edge, every valid slot is loaded with pending=1. Invalid slots are loaded with pending=0.
- Requests with req_we_i == 0 are accepted and dropped (pending=0).
- Group selection, combinational from the batch register each cycle:
  - Scan pending entries lowest index first.
  - Take the first WPORTS_NUM distinct addresses, in order of first occurrence.
  - The j-th selected address goes to RAM port j.
- Merge:
  - For a selected address, all pending entries with that address are combined byte-wise.
  - For each byte, the highest-index entry with that byte enabled supplies it.
  - we = OR of the merged enables.
  - All merged entries are cleared at the edge.
- Outputs are registered. Selected groups load the output registers; unused ports get en_w_o=0 and we_o=0, with addr and data don't-care.
- req_ready_o = rst ? 0 : (no pending entries remain after this cycle's group), i.e. the batch is empty or the current group drains it. A new batch therefore loads on the same edge the last group issues, so there is no bubble.
- States:
  - IDLE (no pending) → DRAIN on accepting a batch that has any pending entry.
  - DRAIN → DRAIN while entries remain after the group.
  - DRAIN → IDLE when the group empties the batch and no new valid arrives.
  - DRAIN → DRAIN (new batch) when the group empties the batch and a new valid arrives.
- Ordering guarantees:
  - A later batch always writes after an earlier one.
  - Within a batch, one address never appears in two groups (macro on), so no ordering hazard exists.
  - Different addresses carry no ordering constraint.

## Timing
- Reset: batch cleared; en_w_o=0, we_o=0, waddr_o=0, data_o=0, busy_o=0, req_ready_o=0 while rst=1. req_ready_o=1 in the first cycle after rst drops.
- Latency: a batch accepted at edge N issues group k (k=1..) on RAM ports in the cycle after edge N+k.
- Throughput: a batch of ≤ WPORTS_NUM distinct addresses takes 1 cycle, and req_ready_o stays high. A batch with D distinct addresses holds req_ready_o low for ceil(D/WPORTS_NUM)−1 cycles.
- busy_o is registered: 1 in every cycle the batch register holds a pending entry.
- rst mid-drain: on the next edge, pending entries are discarded and output registers are cleared. The RAM is not written by discarded entries.
- Source rule: sources hold valid and payload stable until accepted.

## Configuration
- RAM_WAW_MERGE_EN defined: same-address entries are merged byte-wise into one port write, as above.
- RAM_WAW_MERGE_EN undefined: no merging.
  - A group selects at most one entry per address: the lowest-index pending one.
  - Remaining same-address entries issue in later cycles, in index order.
  - Result is identical in RAM contents, at the cost of more cycles.

## Test plan
- Reset: hold rst 3 cycles with all valids high → all outputs 0 and req_ready_o=0 throughout; cycle after release req_ready_o=1, busy_o=0.
- Four valids, addresses 1,2,3,4, we=0xFF, data=0xA0..A3, accepted at edge N → cycle after N+1: en_w_o=6'b001111, waddr_o[0..3]=1..4, data_o matches; req_ready_o never drops.
- Eight distinct addresses 10..17 → group 1 on ports 0-5 (addr 10..15), next cycle ports 0-1 (addr 16,17), en_w_o=6'b000011; req_ready_o low exactly 1 cycle.
- WAW, macro on: slot0 addr 5 data 0x1111_1111_1111_1111 we=0xFF; slot3 addr 5 data 0x2222_2222_2222_2222 we=0x0F → single port 0 write: data 0x1111_1111_2222_2222, we 0xFF, en_w_o=6'b000001.
- Same stimulus, macro off → port 0 writes slot0 (we 0xFF), next cycle port 0 writes slot3 (we 0x0F); req_ready_o low 1 cycle.
- rst asserted during group 1 of the 8-address batch → no group 2 issued; en_w_o=0 after the reset edge; busy_o=0.
